regfile_mp: RTL
===============

// Module: regfile_mp
// PURPOSE
//  Parametrised multi-port register file. Generalises the 32x32 2R1W file.
//  Adds: configurable width/depth, two write ports with byte enables, optional
//  write-to-read bypass, optional hardwired-zero r0, and a sequential clear engine.
//  Sits in the CPU datapath between decode (read addrs) and writeback (write ports).
// PARAMETERS
//  DATA_W    32  data width in bits; must be a multiple of 8
//  ADDR_W    5   address width; DEPTH = 2**ADDR_W entries
//  BYPASS    1   1 = a same-cycle write is forwarded to a matching read port
//  ZERO_REG  1   1 = entry 0 always reads 0, writes to it are dropped
// PORTS
//  clk     in   1          rising-edge clock
//  rst     in   1          asynchronous, active-low reset
//  we1     in   1          write port 1 enable
//  waddr1  in   ADDR_W     write port 1 address
//  wdata1  in   DATA_W     write port 1 data
//  wbe1    in   DATA_W/8   write port 1 byte enables (bit i -> byte i)
//  we2     in   1          write port 2 enable
//  waddr2  in   ADDR_W     write port 2 address
//  wdata2  in   DATA_W     write port 2 data
//  wbe2    in   DATA_W/8   write port 2 byte enables
//  raddr1  in   ADDR_W     read port 1 address
//  rdata1  out  DATA_W     read port 1 data (combinational)
//  raddr2  in   ADDR_W     read port 2 address
//  rdata2  out  DATA_W     read port 2 data (combinational)
//  clr     in   1          single-cycle request to zero the whole file
//  busy    out  1          1 while clear sweep is running
// BEHAVIOUR
//  - FSM states: CLEAR, IDLE. Sweep counter cnt is ADDR_W bits wide.
//  - rst low (async): state=CLEAR, cnt=0, busy=1. The array itself is not reset.
//    rdata1/rdata2 = 0 while busy=1.
//  - CLEAR: each cycle writes 0 to entry cnt, then cnt++.
//    When cnt==DEPTH-1 is written, next state=IDLE and busy=0.
//    The sweep takes exactly DEPTH cycles after reset release.
//  - IDLE + clr=1: next state=CLEAR, cnt=0, busy=1 next cycle.
//    A write in the same cycle as clr is dropped.
//  - clr=1 while in CLEAR: the sweep restarts at cnt=0.
//  - While busy=1: we1/we2 are ignored (dropped, not queued).
//  - Writes (IDLE only) take effect on the rising edge.
//    Only bytes with wbe=1 are updated; other bytes keep their old value.
//  - Same address on both write ports: per byte, port 2 wins where wbe2=1;
//    otherwise port 1's byte is written if wbe1=1.
//  - ZERO_REG=1: writes to addr 0 are dropped; a read of addr 0 returns 0,
//    bypass included.
//  - Reads are asynchronous, with 0-cycle latency from raddr.
//  - BYPASS=1, IDLE: if an enabled write matches raddr, rdata = merged value:
//    old entry overlaid by wdata1 bytes (wbe1) then wdata2 bytes (wbe2),
//    using the same priority as the write.
//  - BYPASS=0: a read returns the pre-edge contents; new data is visible the cycle after the write.
//  - Address out of range is impossible (DEPTH = 2**ADDR_W); no wrap-around logic.
// TESTING
//  1. Reset/clear: drop rst, release -> busy=1 for 32 cycles, then 0.
//     All 32 entries read 0; rdata=0 throughout busy.
//  2. Basic write/read: we1, waddr1=3, wdata1=FFFF_FFFF, wbe1=F.
//     Next cycle raddr1=3 -> FFFF_FFFF; raddr2=12 -> 0.
//  3. Byte enables and port priority: entry 6 = 0000_0000.
//     Same cycle: we1 addr6 data 1111_1111 wbe1=F; we2 addr6 data AAAA_AAAA wbe2=3.
//     -> entry 6 = 1111_AAAA.
//  4. Bypass: BYPASS=1, entry 9 = 0; we1 addr9 data 0000_FFFF wbe=F, raddr1=9 in the same cycle
//     -> rdata1=0000_FFFF in the same cycle. BYPASS=0 -> rdata1=0 in that cycle, 0000_FFFF next.
//  5. Zero reg: ZERO_REG=1, we1 addr0 data DEAD_BEEF -> raddr1=0 reads 0 in the same and next cycle.
//  6. Clear mid-run: entries 3,6,9 nonzero, pulse clr. Write to 9 in cycle 5 of busy is dropped.
//     clr again at cycle 10 -> busy lasts 10+32 cycles total; afterwards all entries 0.

Source files
------------

// File: rtl/regfile_mp.sv
// Parametrised 2-write/2-read register file with byte enables, optional
// write-to-read bypass, optional hardwired-zero entry 0 and a sequential clear engine.
module regfile_mp #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter int BYPASS   = 1,
   parameter int ZERO_REG = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  we1,
   input  logic [ADDR_W-1:0]     waddr1,
   input  logic [DATA_W-1:0]     wdata1,
   input  logic [DATA_W/8-1:0]   wbe1,
   input  logic                  we2,
   input  logic [ADDR_W-1:0]     waddr2,
   input  logic [DATA_W-1:0]     wdata2,
   input  logic [DATA_W/8-1:0]   wbe2,
   input  logic [ADDR_W-1:0]     raddr1,
   output logic [DATA_W-1:0]     rdata1,
   input  logic [ADDR_W-1:0]     raddr2,
   output logic [DATA_W-1:0]     rdata2,
   input  logic                  clr,
   output logic                  busy
);

   localparam int NB    = DATA_W / 8;
   localparam int DEPTH = 2 ** ADDR_W;

   typedef enum logic {CLEAR, IDLE} state_t;

   state_t              state;
   logic [ADDR_W-1:0]   cnt;
   logic [DATA_W-1:0]   mem [DEPTH];
   logic                wen1;
   logic                wen2;

   // Writes only land in IDLE, never alongside a clear request, never on a hardwired zero.
   assign wen1 = we1 && (state == IDLE) && !clr && !((ZERO_REG != 0) && (waddr1 == '0));
   assign wen2 = we2 && (state == IDLE) && !clr && !((ZERO_REG != 0) && (waddr2 == '0));

   // Entry value after this cycle's writes: port 1 bytes first, port 2 bytes on top.
   function automatic logic [DATA_W-1:0] merge(input logic [ADDR_W-1:0] a,
                                               input logic [DATA_W-1:0] old);
      logic [DATA_W-1:0] v;
      v = old;
      for (int b = 0; b < NB; b++) begin
         if (wen1 && (waddr1 == a) && wbe1[b]) v[8*b +: 8] = wdata1[8*b +: 8];
         if (wen2 && (waddr2 == a) && wbe2[b]) v[8*b +: 8] = wdata2[8*b +: 8];
      end
      return v;
   endfunction

   function automatic logic [DATA_W-1:0] rd(input logic [ADDR_W-1:0] a);
      if (busy || ((ZERO_REG != 0) && (a == '0))) return '0;
      else if (BYPASS != 0)                         return merge(a, mem[a]);
      else                                          return mem[a];
   endfunction

   always_comb begin
      rdata1 = rd(raddr1);
      rdata2 = rd(raddr2);
   end

   // Both ports write the fully merged word, so a shared address resolves identically.
   always_ff @(posedge clk) begin
      if (state == CLEAR) begin
         mem[cnt] <= '0;
      end else begin
         if (wen1) mem[waddr1] <= merge(waddr1, mem[waddr1]);
         if (wen2) mem[waddr2] <= merge(waddr2, mem[waddr2]);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= CLEAR;
         cnt   <= '0;
         busy  <= 1'b1;
      end else begin
         case (state)
            CLEAR: begin
               if (clr) begin
                  cnt <= '0;
               end else begin
                  if (cnt == {ADDR_W{1'b1}}) begin
                     state <= IDLE;
                     busy  <= 1'b0;
                  end
                  cnt <= cnt + 1'b1;
               end
            end
            IDLE: begin
               if (clr) begin
                  state <= CLEAR;
                  cnt   <= '0;
                  busy  <= 1'b1;
               end
            end
            default: begin
               state <= CLEAR;
               cnt   <= '0;
               busy  <= 1'b1;
            end
         endcase
      end
   end

endmodule
